uart_framebuffer: RTL and testbench
===================================

# uart_framebuffer

Double-buffered, parametrised frame buffer loader between the USB UART byte stream and an OLED graphics driver. It unpacks incoming bytes into multi-plane pixel rows, writes each completed frame into a back bank, and swaps banks atomically at frame end so the display never shows a torn frame. It also adds an idle-timeout resync, a frame-done acknowledge byte back to the host, and a registered row read port for the display engine.

## Interface
- ROWS, 80, rows per frame
- COLS, 16, pixels per row (COLS*PLANES must be a multiple of 8)
- PLANES, 2, bits per pixel; legal values are 1, 2, 4
- TIMEOUT, 480000, idle cycles mid-frame before the partial frame is discarded (0 disables the timeout)

- clk_48mhz  in  1  clock
- reset  in  1  reset, synchronous, active-low
- rx_data  in  8  byte from the UART
- rx_strobe  in  1  one-cycle valid for rx_data
- tx_data  out  8  acknowledge byte
- tx_strobe  out  1  one-cycle valid for tx_data
- rd_row  in  $clog2(ROWS)  row requested by the display
- rd_pixels  out  COLS*PLANES  row word from the front bank; plane p occupies bits [p*COLS +: COLS]
- front_bank  out  1  bank currently displayed
- frame_done  out  1  one-cycle pulse when a frame is committed
- abort  out  1  one-cycle pulse when a partial frame is discarded by timeout
- busy  out  1  high while a frame is partially received

## Operation
- Derived constants:
  - PPB = 8/PLANES (pixels per byte)
  - BPR = COLS*PLANES/8 (bytes per row)
  - Frame length = ROWS*BPR bytes
- Unpacking:
  - Pixel k of a byte is rx_data[k*PLANES +: PLANES]; bit p of that pixel goes to plane p.
  - Byte index b in a row (0 = first received) fills columns c = (BPR-1-b)*PPB + k, for k = 0..PPB-1.
  - Plane-p bit of column c lands at word bit p*COLS + c.
- Row accumulation:
  - Bytes accumulate in a COLS*PLANES row register.
  - On the row's last byte, the full word (including that byte) is written to back bank row wr_row.
  - Memory is written only in whole words, so it is BRAM-inferable.
- Write pointer: the pair wr_row / wr_byte advances on each rx_strobe.
  - wr_byte wraps BPR-1 → 0 and increments wr_row.
  - The frame's last byte (wr_row = ROWS-1, wr_byte = BPR-1) wraps both counters to 0.
- Frame commit, on the frame's last byte:
  - Next edge: front_bank toggles, frame_done pulses, frame_count increments (8-bit, wraps 255 → 0), and tx_strobe pulses with tx_data = the new frame_count.
  - Writes always target bank ~front_bank. The last row write and the toggle occur on the same edge, so the write goes to the old back bank.
- busy is high when (wr_row, wr_byte) ≠ (0, 0).
- Timeout:
  - The idle counter clears on each rx_strobe and counts only while busy.
  - When it reaches TIMEOUT: pointer and row register clear, abort pulses, no bank swap, no tx.
  - An rx_strobe on the same cycle as expiry wins: the byte is accepted and the counter clears.
- Reset (reset = 0), which also applies mid-frame:
  - Clears the pointer, row register, idle counter, front_bank, frame_count and all outputs.
  - Memory contents are not cleared.
  - rx_strobe is ignored while in reset.

## Timing
- Reset values: tx_data 0, tx_strobe 0, rd_pixels 0, front_bank 0, frame_done 0, abort 0, busy 0.
- Read latency: rd_pixels is registered, one cycle after rd_row is sampled, from the bank indicated by front_bank in the sampling cycle.
  - Reading the edge after a swap returns new-bank data.
- rx_strobe may be asserted every cycle; throughput is 1 byte/cycle with no stall.
- Commit latency: frame_done, tx_strobe and the front_bank toggle are all visible 1 cycle after the final rx_strobe.
  - A new frame's first byte may arrive in that same cycle.
- tx_strobe has no backpressure; the host must not send a new full frame faster than the UART drains one byte.

## Test plan
- Reset: hold reset = 0 with rx_strobe toggling → all outputs 0, no frame_done, front_bank 0.
- Unpack, with ROWS=4, COLS=16, PLANES=2: send row 0 = {0x55, 0x00, 0x00, 0xAA}, rows 1-3 = 0x00, then read rd_row=0 → rd_pixels = 0x000FF000 one cycle later; front_bank = 1.
- Back-to-back: two 16-byte frames with rx_strobe held high → frame_done pulses at bytes 16+1 and 32+1; tx_data = 0x01 then 0x02; front_bank goes 1 then 0.
- Timeout, TIMEOUT=100: send 6 bytes, then idle 100 cycles → abort pulses once, busy falls, front_bank unchanged, no tx_strobe; a following 16-byte frame commits normally.
- Swap read: hold rd_row=0 across the commit edge with different row 0 data in each bank → rd_pixels switches exactly one cycle after front_bank toggles.
- Mid-frame reset: send 10 bytes, drive reset low for 1 cycle → busy 0, frame_count 0; the next 16 bytes produce tx_data = 0x01.

Source files
------------

// File: rtl/uart_framebuffer.sv
// UART byte stream to double-buffered multi-plane OLED frame store.
// Bytes unpack into a row word; each finished frame swaps banks atomically.
module uart_framebuffer #(
    parameter int ROWS    = 80,
    parameter int COLS    = 16,
    parameter int PLANES  = 2,
    parameter int TIMEOUT = 480000
) (
    input  logic                       clk_48mhz,
    input  logic                       reset,
    input  logic [7:0]                 rx_data,
    input  logic                       rx_strobe,
    output logic [7:0]                 tx_data,
    output logic                       tx_strobe,
    input  logic [$clog2(ROWS)-1:0]    rd_row,
    output logic [COLS*PLANES-1:0]     rd_pixels,
    output logic                       front_bank,
    output logic                       frame_done,
    output logic                       abort,
    output logic                       busy
);

    localparam int W   = COLS * PLANES;
    localparam int PPB = 8 / PLANES;
    localparam int BPR = W / 8;
    localparam int RW  = $clog2(ROWS);
    localparam int BW  = (BPR > 1) ? $clog2(BPR) : 1;
    localparam int TW  = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    logic [RW-1:0] r_wr_row;
    logic [BW-1:0] r_wr_byte;
    logic [W-1:0]  r_row;
    logic [TW-1:0] r_idle;
    logic          r_front;
    logic [7:0]    r_count;
    logic [7:0]    r_tx_data;
    logic          r_tx_strobe;
    logic          r_done;
    logic          r_abort;
    logic [W-1:0]  r_rd;
    logic [W-1:0]  r_mem [2][ROWS];

    logic [W-1:0]  w_spread;
    logic [W-1:0]  w_mask;
    logic [W-1:0]  w_row_next;
    int            w_shift;
    logic          w_last_byte;
    logic          w_last_row;
    logic          w_row_end;
    logic          w_busy;
    logic          w_expire;

    // Place the byte's pixels at column 0, then shift to this byte's column slot.
    always_comb begin
        w_spread = '0;
        w_mask   = '0;
        for (int k = 0; k < PPB; k++) begin
            for (int p = 0; p < PLANES; p++) begin
                w_spread[p*COLS + k] = rx_data[k*PLANES + p];
                w_mask[p*COLS + k]   = 1'b1;
            end
        end
        w_shift    = (BPR - 1 - int'(r_wr_byte)) * PPB;
        w_row_next = (r_row & ~(w_mask << w_shift)) | (w_spread << w_shift);
    end

    assign w_last_byte = (r_wr_byte == BW'(BPR - 1));
    assign w_last_row  = (r_wr_row == RW'(ROWS - 1));
    assign w_row_end   = rx_strobe && w_last_byte;
    assign w_busy      = (r_wr_row != '0) || (r_wr_byte != '0);
    assign w_expire    = (TIMEOUT != 0) && w_busy && !rx_strobe &&
                         (r_idle == TW'(TIMEOUT - 1));

    always_ff @(posedge clk_48mhz) begin
        if (!reset) begin
            r_wr_row    <= '0;
            r_wr_byte   <= '0;
            r_row       <= '0;
            r_idle      <= '0;
            r_front     <= 1'b0;
            r_count     <= 8'd0;
            r_tx_data   <= 8'd0;
            r_tx_strobe <= 1'b0;
            r_done      <= 1'b0;
            r_abort     <= 1'b0;
            r_rd        <= '0;
        end else begin
            r_tx_strobe <= 1'b0;
            r_done      <= 1'b0;
            r_abort     <= 1'b0;
            r_rd        <= r_mem[r_front][rd_row];
            if (rx_strobe) begin
                r_idle <= '0;
                if (w_last_byte) begin
                    r_wr_byte <= '0;
                    r_row     <= '0;
                    if (w_last_row) begin
                        r_wr_row    <= '0;
                        r_front     <= ~r_front;
                        r_done      <= 1'b1;
                        r_count     <= r_count + 8'd1;
                        r_tx_strobe <= 1'b1;
                        r_tx_data   <= r_count + 8'd1;
                    end else begin
                        r_wr_row <= r_wr_row + RW'(1);
                    end
                end else begin
                    r_wr_byte <= r_wr_byte + BW'(1);
                    r_row     <= w_row_next;
                end
            end else if (w_expire) begin
                r_wr_row  <= '0;
                r_wr_byte <= '0;
                r_row     <= '0;
                r_idle    <= '0;
                r_abort   <= 1'b1;
            end else if (w_busy) begin
                r_idle <= r_idle + TW'(1);
            end else begin
                r_idle <= '0;
            end
        end
    end

    // Whole-word writes to the back bank only; the final row lands before the swap.
    always_ff @(posedge clk_48mhz) begin
        if (reset && w_row_end) begin
            r_mem[~r_front][r_wr_row] <= w_row_next;
        end
    end

    assign tx_data    = r_tx_data;
    assign tx_strobe  = r_tx_strobe;
    assign rd_pixels  = r_rd;
    assign front_bank = r_front;
    assign frame_done = r_done;
    assign abort      = r_abort;
    assign busy       = w_busy;

endmodule

// File: tb/tb_uart_framebuffer.sv
// Directed bench for uart_framebuffer with a 4x16x2 frame (16 bytes).
// Drives and samples 1 ns after each rising edge.
module tb_uart_framebuffer;

    logic        clk_48mhz = 1'b0;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_strobe;
    logic [7:0]  tx_data;
    logic        tx_strobe;
    logic [1:0]  rd_row;
    logic [31:0] rd_pixels;
    logic        front_bank;
    logic        frame_done;
    logic        abort;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int tx_seen;
    int abort_seen;

    uart_framebuffer #(
        .ROWS(4), .COLS(16), .PLANES(2), .TIMEOUT(100)
    ) dut (
        .clk_48mhz (clk_48mhz),
        .reset     (reset),
        .rx_data   (rx_data),
        .rx_strobe (rx_strobe),
        .tx_data   (tx_data),
        .tx_strobe (tx_strobe),
        .rd_row    (rd_row),
        .rd_pixels (rd_pixels),
        .front_bank(front_bank),
        .frame_done(frame_done),
        .abort     (abort),
        .busy      (busy)
    );

    always #10 clk_48mhz = ~clk_48mhz;

    task automatic step();
        @(posedge clk_48mhz);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // row0 is sent MSB byte first; rows 1-3 are zero.
    task automatic send_frame(input logic [31:0] row0);
        for (int i = 0; i < 16; i++) begin
            rx_data   = (i < 4) ? row0[8*(3-i) +: 8] : 8'h00;
            rx_strobe = 1'b1;
            step();
        end
        rx_strobe = 1'b0;
    endtask

    task automatic send_bytes(input int n, input logic [7:0] b);
        for (int i = 0; i < n; i++) begin
            rx_data   = b;
            rx_strobe = 1'b1;
            step();
        end
        rx_strobe = 1'b0;
    endtask

    initial begin
        reset     = 1'b0;
        rx_data   = 8'h00;
        rx_strobe = 1'b0;
        rd_row    = 2'd0;

        for (int i = 0; i < 6; i++) begin
            rx_strobe = i[0];
            rx_data   = 8'hA5;
            step();
            chk("rst_frame_done", frame_done, 0);
        end
        chk("rst_tx_data", tx_data, 0);
        chk("rst_tx_strobe", tx_strobe, 0);
        chk("rst_rd_pixels", rd_pixels, 0);
        chk("rst_front", front_bank, 0);
        chk("rst_abort", abort, 0);
        chk("rst_busy", busy, 0);
        rx_strobe = 1'b0;
        reset     = 1'b1;
        step();

        send_frame(32'h5500_00AA);
        chk("unp_done", frame_done, 1);
        chk("unp_tx_strobe", tx_strobe, 1);
        chk("unp_tx_data", tx_data, 8'h01);
        chk("unp_front", front_bank, 1);
        chk("unp_busy", busy, 0);
        step();
        chk("unp_row0", rd_pixels, 32'h000F_F000);
        chk("unp_done_low", frame_done, 0);
        chk("unp_tx_low", tx_strobe, 0);
        rd_row = 2'd1;
        step();
        chk("unp_row1", rd_pixels, 32'h0000_0000);
        rd_row = 2'd0;

        reset = 1'b0;
        step();
        reset = 1'b1;
        chk("b2b_front0", front_bank, 0);
        chk("b2b_tx0", tx_data, 0);
        for (int i = 0; i < 32; i++) begin
            rx_data   = (i < 4) ? 8'hFF : ((i == 19) ? 8'h01 : 8'h00);
            rx_strobe = 1'b1;
            step();
            chk("b2b_done", frame_done, (i == 15 || i == 31) ? 1 : 0);
            chk("b2b_front", front_bank, (i >= 15 && i < 31) ? 1 : 0);
            if (i == 15) chk("b2b_tx1", tx_data, 8'h01);
            if (i == 31) chk("b2b_tx2", tx_data, 8'h02);
        end
        rx_strobe = 1'b0;
        step();
        chk("b2b_bank0_row0", rd_pixels, 32'h0000_0001);

        send_frame(32'h5500_00AA);
        chk("swp_front", front_bank, 1);
        chk("swp_old", rd_pixels, 32'h0000_0001);
        chk("swp_tx3", tx_data, 8'h03);
        step();
        chk("swp_new", rd_pixels, 32'h000F_F000);

        send_bytes(6, 8'h11);
        chk("to_busy", busy, 1);
        tx_seen    = 0;
        abort_seen = 0;
        for (int i = 0; i < 99; i++) begin
            step();
            tx_seen    += int'(tx_strobe);
            abort_seen += int'(abort);
        end
        chk("to_pre_abort", abort, 0);
        chk("to_pre_busy", busy, 1);
        step();
        abort_seen += int'(abort);
        chk("to_abort", abort, 1);
        chk("to_busy_fall", busy, 0);
        chk("to_front", front_bank, 1);
        step();
        tx_seen    += int'(tx_strobe);
        abort_seen += int'(abort);
        chk("to_abort_once", abort_seen, 1);
        chk("to_no_tx", tx_seen, 0);
        send_frame(32'h0000_000F);
        chk("to_next_done", frame_done, 1);
        chk("to_next_tx", tx_data, 8'h04);
        chk("to_next_front", front_bank, 0);
        step();
        chk("to_next_row0", rd_pixels, 32'h0003_0003);

        send_bytes(1, 8'h00);
        for (int i = 0; i < 99; i++) step();
        send_bytes(1, 8'h00);
        chk("col_abort", abort, 0);
        chk("col_busy", busy, 1);
        for (int i = 0; i < 99; i++) step();
        chk("col_pre_abort", abort, 0);
        step();
        chk("col_abort2", abort, 1);
        chk("col_busy2", busy, 0);

        send_bytes(10, 8'h33);
        chk("mr_busy", busy, 1);
        reset     = 1'b0;
        rx_strobe = 1'b1;
        step();
        chk("mr_busy0", busy, 0);
        chk("mr_front0", front_bank, 0);
        chk("mr_tx0", tx_data, 0);
        chk("mr_done0", frame_done, 0);
        reset     = 1'b1;
        rx_strobe = 1'b0;
        send_frame(32'h0000_0000);
        chk("mr_done", frame_done, 1);
        chk("mr_tx1", tx_data, 8'h01);
        chk("mr_front1", front_bank, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
